// File: rtl/ecc_apb_codec.sv
// ecc_apb_codec: APB-programmable SECDED (extended Hamming) encoder/decoder.
// Software loads the data word, code-word width and noise pattern, then writes CTRL
// to launch encode, decode or full channel (encode, add noise, decode). The result
// appears one cycle after the CTRL write, together with a one-cycle done strobe.
module ecc_apb_codec #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);

    localparam logic [1:0] OP_ENCODE  = 2'd0;
    localparam logic [1:0] OP_DECODE  = 2'd1;
    localparam logic [1:0] OP_CHANNEL = 2'd2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_WIDTH  = 2'd2;
    localparam logic [1:0] REG_NOISE  = 2'd3;

    logic [AMBA_WORD-1:0]  ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0]  data_in_q, data_in_d;
    logic [AMBA_WORD-1:0]  width_q, width_d;
    logic [AMBA_WORD-1:0]  noise_q, noise_d;
    logic                  start_q, start_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            errors_q, errors_d;
    logic                  done_q, done_d;

    logic                  addr_in_range;
    logic                  apb_write;
    logic [1:0]            reg_sel;
    logic [31:0]           codec_data;
    logic [1:0]            codec_errors;
    logic                  unused_addr_bits;

    // Code-word length in bits for a CODEWORD_WIDTH setting; setting 3 behaves as 32b.
    function automatic int width_bits(input logic [1:0] w);
        int n;
        case (w)
            2'd0:    n = 8;
            2'd1:    n = 16;
            default: n = 32;
        endcase
        return n;
    endfunction

    // Builds the extended Hamming code word for the low data bits of an n-bit code.
    function automatic logic [31:0] hamming_encode(input logic [31:0] data, input int n);
        logic [31:0] cw;
        logic        par;
        int          di;
        cw = '0;
        di = 0;
        for (int p = 1; p < 32; p++) begin
            if (p < n && (p & (p - 1)) != 0) begin
                cw[p-1] = data[di];
                di      = di + 1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if ((1 << i) < n) begin
                par = 1'b0;
                for (int p = 1; p < 32; p++) begin
                    if (p < n && p[i]) par = par ^ cw[p-1];
                end
                cw[(1 << i) - 1] = par;
            end
        end
        par = 1'b0;
        for (int j = 0; j < 31; j++) begin
            if (j < n - 1) par = par ^ cw[j];
        end
        cw[n-1] = par;
        return cw;
    endfunction

    // Corrects/detects errors in an n-bit received word; returns {errors, data}.
    function automatic logic [33:0] hamming_decode(input logic [31:0] r_in, input int n);
        logic [31:0] r;
        logic [31:0] data;
        logic [4:0]  s;
        logic        q;
        logic [1:0]  errs;
        int          di;
        r = r_in;
        s = '0;
        q = 1'b0;
        for (int p = 1; p < 32; p++) begin
            if (p < n && r[p-1]) s = s ^ 5'(p);
        end
        for (int j = 0; j < 32; j++) begin
            if (j < n) q = q ^ r[j];
        end
        errs = 2'd0;
        if (q) begin
            errs = 2'd1;
            if (s == 5'd0) r[n-1] = ~r[n-1];
            else           r[s-5'd1] = ~r[s-5'd1];
        end else if (s != 5'd0) begin
            errs = 2'd2;
        end
        data = '0;
        di   = 0;
        for (int p = 1; p < 32; p++) begin
            if (p < n && (p & (p - 1)) != 0) begin
                data[di] = r[p-1];
                di       = di + 1;
            end
        end
        return {errs, data};
    endfunction

    assign reg_sel          = PADDR[3:2];
    assign addr_in_range    = (PADDR[AMBA_ADDR_WIDTH-1:4] == '0);
    assign apb_write        = PSEL && PENABLE && PWRITE && addr_in_range;
    assign unused_addr_bits = ^PADDR[1:0];

    // Register file updates and operation launch on CTRL writes of 0..2.
    always_comb begin
        ctrl_d    = ctrl_q;
        data_in_d = data_in_q;
        width_d   = width_q;
        noise_d   = noise_q;
        start_d   = 1'b0;
        op_d      = op_q;
        if (apb_write) begin
            case (reg_sel)
                REG_CTRL: begin
                    ctrl_d = PWDATA;
                    if (PWDATA <= AMBA_WORD'(2)) begin
                        start_d = 1'b1;
                        op_d    = PWDATA[1:0];
                    end
                end
                REG_DATA:  data_in_d = PWDATA;
                REG_WIDTH: width_d   = PWDATA;
                default:   noise_d   = PWDATA;
            endcase
        end
    end

    // Codec datapath for the launched operation, using the registers as they stand.
    always_comb begin
        logic [31:0] din;
        logic [31:0] cw;
        logic [31:0] rx;
        logic [33:0] dec;
        int          n;
        n   = width_bits(width_q[1:0]);
        din = 32'(data_in_q);
        cw  = hamming_encode(din, n);
        rx  = din;
        if (op_q == OP_CHANNEL) rx = cw ^ 32'(noise_q);
        dec = hamming_decode(rx, n);
        codec_data   = dec[31:0];
        codec_errors = dec[33:32];
        if (op_q == OP_ENCODE) begin
            codec_data   = cw;
            codec_errors = 2'd0;
        end
    end

    // Result registers load only in the cycle after a launch; done mirrors the launch.
    always_comb begin
        data_out_d = data_out_q;
        errors_d   = errors_q;
        done_d     = start_q;
        if (start_q && (op_q == OP_ENCODE || op_q == OP_DECODE || op_q == OP_CHANNEL)) begin
            data_out_d = DATA_WIDTH'(codec_data);
            errors_d   = codec_errors;
        end
    end

    // State registers with synchronous reset taking priority over bus writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            data_in_q  <= '0;
            width_q    <= '0;
            noise_q    <= '0;
            start_q    <= 1'b0;
            op_q       <= 2'd0;
            data_out_q <= '0;
            errors_q   <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            width_q    <= width_d;
            noise_q    <= noise_d;
            start_q    <= start_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
            errors_q   <= errors_d;
            done_q     <= done_d;
        end
    end

    // Combinational read mux; unmapped addresses and non-read cycles return zero.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && addr_in_range) begin
            case (reg_sel)
                REG_CTRL:  PRDATA = ctrl_q;
                REG_DATA:  PRDATA = data_in_q;
                REG_WIDTH: PRDATA = width_q;
                default:   PRDATA = noise_q;
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = errors_q;
    assign operation_done = done_q;

endmodule

// File: tb/tb_ecc_apb_codec.sv
// Testbench for ecc_apb_codec: directed and randomized APB traffic checked against
// a position-list reference model of the extended Hamming code.
module tb_ecc_apb_codec;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int assertCount = 0;
    int failCount   = 0;

    ecc_apb_codec #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cwLen(input int w);
        return (w == 0) ? 8 : (w == 1) ? 16 : 32;
    endfunction

    function automatic bit isPow2(input int p);
        return $countones(p) == 1;
    endfunction

    // Reference encoder: data bits go to the non-power-of-two positions in order,
    // each parity bit 2^i makes the group of positions with bit i set even.
    function automatic logic [31:0] refEncode(input logic [31:0] d, input int n);
        logic [31:0] cw = '0;
        int idx = 0;
        for (int p = 1; p < n; p++)
            if (!isPow2(p)) begin cw[p-1] = d[idx]; idx++; end
        for (int i = 0; (1 << i) < n; i++) begin
            int cnt = 0;
            for (int p = 1; p < n; p++)
                if (((p >> i) & 1) == 1 && cw[p-1]) cnt++;
            cw[(1 << i) - 1] = cnt[0];
        end
        cw[n-1] = $countones(cw) % 2 == 1;
        return cw;
    endfunction

    function automatic logic [31:0] refExtract(input logic [31:0] r, input int n);
        logic [31:0] d = '0;
        int idx = 0;
        for (int p = 1; p < n; p++)
            if (!isPow2(p)) begin d[idx] = r[p-1]; idx++; end
        return d;
    endfunction

    // Reference decoder by nearest-codeword search: valid -> 0 errors, one flip
    // away from a valid word -> 1 error, otherwise 2 errors with raw data.
    function automatic logic [33:0] refDecode(input logic [31:0] rIn, input int n);
        logic [63:0] m = (64'd1 << n) - 64'd1;
        logic [31:0] r = rIn & m[31:0];
        logic [31:0] t;
        if (refEncode(refExtract(r, n), n) == r) return {2'd0, refExtract(r, n)};
        for (int j = 0; j < n; j++) begin
            t = r ^ (32'd1 << j);
            if (refEncode(refExtract(t, n), n) == t) return {2'd1, refExtract(t, n)};
        end
        return {2'd2, refExtract(r, n)};
    endfunction

    task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apbRead(input logic [31:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        #1;
        data = PRDATA;
        PSEL = 1'b0;
    endtask

    // Launches an operation via CTRL and checks the result one cycle after capture.
    task automatic applyStimulus(input logic [1:0] op, input string tag,
                                 input logic [31:0] expData, input logic [1:0] expErr);
        apbWrite(32'h0, {30'd0, op});
        @(posedge clk); #1;
        checkOutput({tag, "_done"}, {31'd0, operation_done}, 32'd1);
        checkOutput({tag, "_data"}, data_out, expData);
        checkOutput({tag, "_err"}, {30'd0, num_of_errors}, {30'd0, expErr});
        @(posedge clk); #1;
        checkOutput({tag, "_doneFall"}, {31'd0, operation_done}, 32'd0);
    endtask

    logic [31:0] rd, d, nz, cw, kMask;
    logic [63:0] m64;
    logic [33:0] ref34;
    int n;

    initial begin
        rst = 1'b1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_data", data_out, 32'd0);
        checkOutput("rst_err", {30'd0, num_of_errors}, 32'd0);
        checkOutput("rst_done", {31'd0, operation_done}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            apbRead(32'(a * 4), rd);
            checkOutput("rst_read", rd, 32'd0);
        end

        // Directed cases from the 8-bit geometry.
        apbWrite(32'h8, 32'd0);
        apbWrite(32'h4, 32'hB);
        applyStimulus(2'd0, "enc_B", 32'h55, 2'd0);
        apbWrite(32'h4, 32'h55);
        applyStimulus(2'd1, "dec_55", 32'h0B, 2'd0);
        apbWrite(32'h4, 32'h51);
        applyStimulus(2'd1, "dec_51", 32'h0B, 2'd1);
        apbWrite(32'h4, 32'hB);
        apbWrite(32'hC, 32'h04);
        applyStimulus(2'd2, "ch_n04", 32'h0B, 2'd1);
        apbWrite(32'hC, 32'h80);
        applyStimulus(2'd2, "ch_n80", 32'h0B, 2'd1);
        apbWrite(32'hC, 32'h05);
        ref34 = refDecode(32'h55 ^ 32'h05, 8);
        applyStimulus(2'd2, "ch_n05", ref34[31:0], 2'd2);

        // Random encode / decode / channel at every width, including setting 3.
        for (int w = 0; w < 4; w++) begin
            n = cwLen(w);
            apbWrite(32'h8, 32'(w));
            for (int it = 0; it < 8; it++) begin
                d = $urandom; nz = $urandom;
                apbWrite(32'h4, d);
                applyStimulus(2'd0, "rnd_enc", refEncode(d, n), 2'd0);
                ref34 = refDecode(d, n);
                applyStimulus(2'd1, "rnd_dec", ref34[31:0], ref34[33:32]);
                apbWrite(32'hC, nz);
                ref34 = refDecode(refEncode(d, n) ^ nz, n);
                applyStimulus(2'd2, "rnd_ch", ref34[31:0], ref34[33:32]);
            end
        end

        // Exhaustive single and double noise patterns at 16 and 32 bits.
        for (int w = 1; w < 3; w++) begin
            n = cwLen(w);
            m64 = (64'd1 << (n - n / 8 - 1 - (n == 8 ? 0 : 1) + (n == 32 ? 0 : 0))) - 64'd1;
            kMask = (n == 16) ? 32'h7FF : 32'h3FF_FFFF;
            d = $urandom;
            apbWrite(32'h8, 32'(w));
            apbWrite(32'h4, d);
            for (int i = 0; i < n; i++) begin
                nz = 32'd1 << i;
                if (n == 16) nz = nz | ($urandom << 16);
                apbWrite(32'hC, nz);
                applyStimulus(2'd2, "single", d & kMask, 2'd1);
            end
            for (int i = 0; i < n; i++)
                for (int j = i + 1; j < n; j++) begin
                    nz = (32'd1 << i) | (32'd1 << j);
                    cw = refEncode(d, n) ^ nz;
                    ref34 = refDecode(cw, n);
                    apbWrite(32'hC, nz);
                    applyStimulus(2'd2, "double", ref34[31:0], 2'd2);
                end
        end

        // Register readback, unmapped reads, CTRL=3 launches nothing.
        apbWrite(32'h4, 32'hDEADBEEF);
        apbWrite(32'h8, 32'h0000_0001);
        apbWrite(32'hC, 32'hA5A5_0F0F);
        apbWrite(32'h0, 32'h3);
        @(posedge clk); #1;
        checkOutput("nop_done", {31'd0, operation_done}, 32'd0);
        apbRead(32'h0, rd);  checkOutput("rb_ctrl", rd, 32'h3);
        apbRead(32'h4, rd);  checkOutput("rb_data", rd, 32'hDEADBEEF);
        apbRead(32'h8, rd);  checkOutput("rb_width", rd, 32'h1);
        apbRead(32'hC, rd);  checkOutput("rb_noise", rd, 32'hA5A5_0F0F);
        apbRead(32'h14, rd); checkOutput("rb_unmapped", rd, 32'd0);
        apbWrite(32'h1000_0004, 32'h1234);
        apbRead(32'h4, rd);  checkOutput("rb_highaddr", rd, 32'hDEADBEEF);

        // Reset right after a CTRL write suppresses the pending done.
        apbWrite(32'h4, 32'h7FF);
        applyStimulus(2'd0, "pre_rst", refEncode(32'h7FF, 16), 2'd0);
        apbWrite(32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstop_done", {31'd0, operation_done}, 32'd0);
        checkOutput("rstop_data", data_out, 32'd0);
        checkOutput("rstop_err", {30'd0, num_of_errors}, 32'd0);
        apbWrite(32'h4, 32'h1111);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstop_done2", {31'd0, operation_done}, 32'd0);
        apbRead(32'h4, rd); checkOutput("rst_prio", rd, 32'd0);
        apbRead(32'h8, rd); checkOutput("rst_width", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ecc_apb_codec.md
# ecc_apb_codec

APB-programmable SECDED (extended Hamming) encoder/decoder. Software loads the data word, code-word width and noise pattern into registers. A write to the control register then launches one of three operations: encode, decode, or full channel (encode, inject noise, decode). The result, error count and a one-cycle completion strobe come back on dedicated outputs. The block sits as an APB slave peripheral on the system bus.

## Interface
- AMBA_WORD, 32, APB data width (PWDATA/PRDATA)
- AMBA_ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, width of data_out and maximum code word

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- PADDR  in  AMBA_ADDR_WIDTH  register address
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1=write, 0=read
- PWDATA  in  AMBA_WORD  write data
- PRDATA  out  AMBA_WORD  read data
- data_out  out  DATA_WIDTH  operation result, zero-extended
- operation_done  out  1  one-cycle completion pulse
- num_of_errors  out  2  0, 1 or 2 detected errors

## Operation
- Registers, decoded on PADDR[3:2]:
  - 0x00 CTRL: 0=encode, 1=decode, 2=full channel, 3=no-op.
  - 0x04 DATA_IN.
  - 0x08 CODEWORD_WIDTH: 0=8b, 1=16b, 2=32b; 3 is treated as 2.
  - 0x0C NOISE.
- Writes:
  - Taken when PSEL & PENABLE & PWRITE at a clock edge.
  - Addresses with PADDR[AMBA_ADDR_WIDTH-1:4]≠0 are ignored.
  - Every write to CTRL with value 0–2 launches an operation. Value 3 is stored but launches nothing.
- Reads:
  - PRDATA is combinational: the selected register when PSEL & !PWRITE, else 0.
  - Unmapped addresses read 0.
- Code word geometry:
  - n = 8/16/32; k = 4/11/26 data bits.
  - Hamming positions p=1..n-1 map to codeword[p-1]. Parity bits sit at p = 1,2,4,8,16 (below n). Data bits fill the remaining positions in ascending order, starting from data LSB.
  - The parity bit at p=2^i is the even parity of all positions with bit i set.
  - codeword[n-1] is the even parity of codeword[n-2:0].
- Encode:
  - data = DATA_IN[k-1:0]; data_out = codeword zero-extended; num_of_errors = 0.
- Decode of a received word r (lower n bits):
  - s = XOR of the indices p of all set positions; q = XOR of all n bits.
  - s=0, q=0: 0 errors.
  - q=1: 1 error. Flip position s, or codeword[n-1] if s=0.
  - s≠0, q=0: 2 errors, no correction.
  - data_out = extracted k data bits, zero-extended.
- Decode mode: r = DATA_IN[n-1:0].
- Full channel: r = encode(DATA_IN) XOR NOISE[n-1:0]; then decode r.
- Bits of DATA_IN and NOISE above n (or above k for data) are ignored.

## Timing
- Reset values:
  - All registers 0 (CODEWORD_WIDTH=0 means 8b).
  - data_out=0, num_of_errors=0, operation_done=0.
  - PRDATA follows the combinational rule.
- Latency:
  - CTRL write captured at edge N.
  - At edge N+1: data_out and num_of_errors update, operation_done rises.
  - operation_done falls at N+2 unless another CTRL write was captured at N+1.
  - data_out and num_of_errors hold until the next operation or reset.
- The operation uses DATA_IN, NOISE and CODEWORD_WIDTH as registered before edge N. Writes to those registers in the same cycle as the CTRL write cannot happen on APB.
- Back-to-back CTRL writes (every 2 cycles on APB) each produce their own done pulse. There is no busy state.
- rst asserted at any edge:
  - Clears all registers and outputs.
  - A pending done is suppressed.
  - rst has priority over APB writes in the same cycle.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0; reads of 0x00–0x0C return 0.
- Encode: WIDTH=0, DATA_IN=0xB, CTRL=0 → one cycle later data_out=0x55, num_of_errors=0, operation_done high for one cycle.
- Decode: DATA_IN=0x55, CTRL=1 → data_out=0x0B, errors=0. Repeat with DATA_IN=0x51 → data_out=0x0B, errors=1.
- Full channel, WIDTH=0, DATA_IN=0xB:
  - NOISE=0x04 → 0x0B, errors=1.
  - NOISE=0x80 → 0x0B, errors=1.
  - NOISE=0x05 → errors=2.
- Widths 16 and 32: random data, all single-bit noise positions → data recovered, errors=1; every double-bit pattern → errors=2.
- rst asserted the cycle after a CTRL write → no operation_done pulse, outputs 0. Readback of written registers matches PWDATA.
